// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and registers the
// fetched word with its PC and PC+4. Optional redirect alignment check: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic        misalign
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction
`else
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_if_valid;
    logic        w_if_valid_nxt;
    logic [31:0] r_if_inst;
    logic [31:0] w_if_inst_nxt;
    logic [31:0] r_if_pc;
    logic [31:0] w_if_pc_nxt;
    logic [31:0] r_if_pc_plus4;
    logic [31:0] w_if_pc_plus4_nxt;
    logic        r_misalign;
    logic        w_misalign_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target_aligned;

    assign w_pc_plus4       = r_pc + 32'd4;
    assign w_target_aligned = redirect_target & 32'hFFFF_FFFC;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-datapath decode; redirect outranks stall in RUN
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_if_valid_nxt    = r_if_valid;
        w_if_inst_nxt     = r_if_inst;
        w_if_pc_nxt       = r_if_pc;
        w_if_pc_plus4_nxt = r_if_pc_plus4;
        w_misalign_nxt    = r_misalign;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt    = ST_RUN;
                w_pc_nxt       = RESET_PC;
                w_if_valid_nxt = 1'b0;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    w_if_valid_nxt = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    if (is_misaligned(redirect_target)) begin
                        w_misalign_nxt = 1'b1;
                        w_state_nxt    = ST_HALT;
                    end else begin
                        w_pc_nxt = redirect_target;
                    end
`else
                    w_pc_nxt = w_target_aligned;
`endif
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else begin
                    w_if_inst_nxt     = inst_data;
                    w_if_pc_nxt       = r_pc;
                    w_if_pc_plus4_nxt = w_pc_plus4;
                    w_if_valid_nxt    = 1'b1;
                    w_pc_nxt          = w_pc_plus4;
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: begin
                w_if_valid_nxt = 1'b0;
            end
`endif
            default: begin
                w_state_nxt    = ST_BOOT;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    // PC and IF output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_inst     <= 32'h0000_0000;
            r_if_pc       <= 32'h0000_0000;
            r_if_pc_plus4 <= 32'h0000_0000;
        end else begin
            r_pc          <= w_pc_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_if_inst     <= w_if_inst_nxt;
            r_if_pc       <= w_if_pc_nxt;
            r_if_pc_plus4 <= w_if_pc_plus4_nxt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_misalign_nxt;
        end
    end
    assign misalign = r_misalign;
`else
    assign r_misalign = 1'b0;
    assign misalign   = 1'b0;
`endif

    assign inst_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_inst     = r_if_inst;
    assign if_pc       = r_if_pc;
    assign if_pc_plus4 = r_if_pc_plus4;

endmodule
